// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the multi-cycle ALU.
package alu_pkg;

    localparam int unsigned ALUSEL_W = 4;

    typedef enum logic [3:0] {
        OP_PASSA = 4'h0,
        OP_PASSB = 4'h1,
        OP_INCA  = 4'h2,
        OP_INCB  = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_SHR1  = 4'h8,
        OP_SHL1  = 4'h9,
        OP_XOR   = 4'hA,
        OP_NOT   = 4'hB,
        OP_ADC   = 4'hC,
        OP_SHRN  = 4'hD,
        OP_SHLN  = 4'hE,
        OP_MUL   = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2
    } alu_state_e;

    // Opcodes at or above this value run on the iterative datapath.
    localparam logic [3:0] OP_ITER_MIN = 4'hD;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op >= OP_ITER_MIN);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath for opcodes 0..C.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         ovf_o
);

    logic [W:0] sum;

    always_comb begin
        sum      = '0;
        result_o = '0;
        carry_o  = 1'b0;
        ovf_o    = 1'b0;
        case (op_i)
            OP_PASSA: result_o = a_i;
            OP_PASSB: result_o = b_i;
            OP_INCA: begin
                sum      = {1'b0, a_i} + (W+1)'(1);
                result_o = sum[W-1:0];
                carry_o  = sum[W];
                ovf_o    = ~a_i[W-1] & sum[W-1];
            end
            OP_INCB: begin
                sum      = {1'b0, b_i} + (W+1)'(1);
                result_o = sum[W-1:0];
                carry_o  = sum[W];
                ovf_o    = ~b_i[W-1] & sum[W-1];
            end
            OP_ADD, OP_ADC: begin
                sum      = {1'b0, a_i} + {1'b0, b_i}
                         + (W+1)'((op_i == OP_ADC) ? cin_i : 1'b0);
                result_o = sum[W-1:0];
                carry_o  = sum[W];
                ovf_o    = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            // Bit W of the wide difference is the borrow.
            OP_SUB: begin
                sum      = {1'b0, a_i} - {1'b0, b_i};
                result_o = sum[W-1:0];
                carry_o  = sum[W];
                ovf_o    = (a_i[W-1] != b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_SHR1: begin
                result_o = {1'b0, a_i[W-1:1]};
                carry_o  = a_i[0];
            end
            OP_SHL1: begin
                result_o = {a_i[W-2:0], 1'b0};
                carry_o  = a_i[W-1];
            end
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle ops via alu_comb, iterative N-bit shifts and
// shift-add multiply, with registered result and CF/ZF/NF/VF flags.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH_DATA_LENGTH   = 8,
    parameter int unsigned WIDTH_ALUSEL_LENGTH = 4
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Start,
    input  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
    input  logic                           WriteCZ,
    input  logic [WIDTH_DATA_LENGTH-1:0]   DataA,
    input  logic [WIDTH_DATA_LENGTH-1:0]   DataB,
    output logic                           Ready,
    output logic                           Done,
    output logic [WIDTH_DATA_LENGTH-1:0]   DataOut,
    output logic                           CF,
    output logic                           ZF,
    output logic                           NF,
    output logic                           VF
);

    localparam int unsigned W       = WIDTH_DATA_LENGTH;
    localparam int unsigned SHAMT_W = $clog2(W);
    localparam int unsigned CNT_W   = $clog2(W + 1);

    alu_state_e         state_q;
    alu_op_e            op_q;
    logic               wcz_q;
    logic [W-1:0]       mcand_q;
    logic [2*W-1:0]     prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               done_q;
    logic [W-1:0]       dout_q;
    logic               cf_q, zf_q, nf_q, vf_q;

    logic [3:0]         sel;
    logic [SHAMT_W-1:0] shamt;
    logic [W-1:0]       comb_res;
    logic               comb_carry, comb_ovf;

    logic [2*W-1:0]     step_prod;
    logic               step_cy;
    logic [W:0]         mac_sum;

    logic               fin_valid;
    logic [W-1:0]       fin_res;
    logic               fin_cy, fin_ovf, fin_wcz;

    assign sel   = 4'(ALUSel);
    assign shamt = DataB[SHAMT_W-1:0];

    alu_comb #(.W(W)) u_comb (
        .op_i     (sel),
        .a_i      (DataA),
        .b_i      (DataB),
        .cin_i    (cf_q),
        .result_o (comb_res),
        .carry_o  (comb_carry),
        .ovf_o    (comb_ovf)
    );

    // One iteration step; prod_q low half is the shift accumulator, and for
    // multiply {high, low} is the partial product with the multiplier in low.
    always_comb begin
        step_prod = prod_q;
        step_cy   = 1'b0;
        mac_sum   = '0;
        case (op_q)
            OP_SHRN: begin
                step_prod[W-1:0] = {1'b0, prod_q[W-1:1]};
                step_cy          = prod_q[0];
            end
            OP_SHLN: begin
                step_prod[W-1:0] = {prod_q[W-2:0], 1'b0};
                step_cy          = prod_q[W-1];
            end
            OP_MUL: begin
                mac_sum   = {1'b0, prod_q[2*W-1:W]}
                          + {1'b0, (prod_q[0] ? mcand_q : W'(0))};
                step_prod = {mac_sum, prod_q[W-1:1]};
                step_cy   = |step_prod[2*W-1:W];
            end
            default: ;
        endcase
    end

    // Result/flag values written at Done, from whichever path completes.
    always_comb begin
        fin_valid = 1'b0;
        fin_res   = comb_res;
        fin_cy    = comb_carry;
        fin_ovf   = comb_ovf;
        fin_wcz   = WriteCZ;
        if (state_q == ST_IDLE && Start) begin
            if (!is_iter_op(sel)) begin
                fin_valid = 1'b1;
            end else if (sel != OP_MUL && shamt == '0) begin
                fin_valid = 1'b1;
                fin_res   = DataA;
                fin_cy    = 1'b0;
                fin_ovf   = 1'b0;
            end
        end else if (state_q == ST_ITER && cnt_q == CNT_W'(1)) begin
            fin_valid = 1'b1;
            fin_res   = step_prod[W-1:0];
            fin_cy    = step_cy;
            fin_ovf   = 1'b0;
            fin_wcz   = wcz_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_PASSA;
            wcz_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            dout_q  <= '0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            vf_q    <= 1'b0;
        end else begin
            done_q <= fin_valid;
            if (fin_valid) begin
                dout_q <= fin_res;
                if (fin_wcz) begin
                    cf_q <= fin_cy;
                    zf_q <= (fin_res == '0);
                    nf_q <= fin_res[W-1];
                    vf_q <= fin_ovf;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        ready_q <= 1'b0;
                        op_q    <= alu_op_e'(sel);
                        wcz_q   <= WriteCZ;
                        mcand_q <= DataA;
                        if (fin_valid) begin
                            state_q <= ST_EXEC;
                        end else begin
                            state_q <= ST_ITER;
                            if (sel == OP_MUL) begin
                                cnt_q  <= CNT_W'(W);
                                prod_q <= {W'(0), DataB};
                            end else begin
                                cnt_q  <= CNT_W'(shamt);
                                prod_q <= {W'(0), DataA};
                            end
                        end
                    end
                end
                ST_ITER: begin
                    prod_q <= step_prod;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (fin_valid) begin
                        state_q <= ST_EXEC;
                    end
                end
                // Done cycle: Ready stays low, back to IDLE afterwards.
                ST_EXEC: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign Ready   = ready_q;
    assign Done    = done_q;
    assign DataOut = dout_q;
    assign CF      = cf_q;
    assign ZF      = zf_q;
    assign NF      = nf_q;
    assign VF      = vf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomised self-checking bench for alu_multicycle (W=8).
module tb_alu_multicycle;
    import alu_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic [3:0] ALUSel;
    logic       WriteCZ;
    logic [7:0] DataA, DataB;
    logic       Ready, Done;
    logic [7:0] DataOut;
    logic       CF, ZF, NF, VF;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [3:0] m_flags;
    logic [7:0] m_out;

    alu_multicycle #(.WIDTH_DATA_LENGTH(8), .WIDTH_ALUSEL_LENGTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ALUSel(ALUSel), .WriteCZ(WriteCZ),
        .DataA(DataA), .DataB(DataB), .Ready(Ready), .Done(Done), .DataOut(DataOut),
        .CF(CF), .ZF(ZF), .NF(NF), .VF(VF)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (Done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: returns {carry, ovf, result}.
    function automatic logic [9:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        int sa, sb, s, sh, p;
        logic [8:0] w;
        logic [7:0] r;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[2:0]);
        r = 8'h00; c = 1'b0; v = 1'b0; w = 9'h000; s = 0; p = 0;
        case (op)
            4'h0: r = a;
            4'h1: r = b;
            4'h2: begin w = {1'b0, a} + 9'd1; r = w[7:0]; c = w[8]; v = (sa + 1 > 127); end
            4'h3: begin w = {1'b0, b} + 9'd1; r = w[7:0]; c = w[8]; v = (sb + 1 > 127); end
            4'h4: begin
                w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                s = sa + sb; v = (s > 127) || (s < -128);
            end
            4'h5: begin
                r = a - b; c = (a < b);
                s = sa - sb; v = (s > 127) || (s < -128);
            end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: begin r = a >> 1; c = a[0]; end
            4'h9: begin r = a << 1; c = a[7]; end
            4'hA: r = a ^ b;
            4'hB: r = ~a;
            4'hC: begin
                w = {1'b0, a} + {1'b0, b} + {8'h00, cin}; r = w[7:0]; c = w[8];
                s = sa + sb + int'(cin); v = (s > 127) || (s < -128);
            end
            4'hD: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
            4'hE: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[8-sh]; end
            default: begin
                p = int'(a) * int'(b); r = p[7:0]; c = (p[15:8] != 8'h00);
            end
        endcase
        return {c, v, r};
    endfunction

    // Issue one op at a negedge with Ready=1, wait for Done (bounded), check it.
    // mode 1 pulses Start at cycle 2; mode 2 scrambles all inputs at cycle 2.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic wcz, input int mode,
                          input int exp_lat, input logic [7:0] exp_out,
                          input logic [3:0] exp_flags);
        int lat;
        check({tag, " ready_in"}, 32'(Ready), 32'd1);
        ALUSel = op; DataA = a; DataB = b; WriteCZ = wcz; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (lat = 1; lat <= 40; lat++) begin
            if (Done === 1'b1) break;
            if (lat == 2 && mode == 1) Start = 1'b1;
            if (lat == 2 && mode == 2) begin
                DataA = ~a; DataB = ~b; ALUSel = 4'h0; WriteCZ = ~wcz;
            end
            @(negedge Clk);
            Start = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " ready_busy"}, 32'(Ready), 32'd0);
        check({tag, " dataout"}, 32'(DataOut), 32'(exp_out));
        check({tag, " flags"}, 32'({CF, ZF, NF, VF}), 32'(exp_flags));
        @(negedge Clk);
        check({tag, " ready_after"}, 32'(Ready), 32'd1);
        check({tag, " done_low"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int d0;
        logic [9:0] rv;
        logic [3:0] op;
        logic [7:0] a, b;
        logic wcz;
        int lat;

        Rst = 1'b1; Start = 1'b0; ALUSel = 4'h0; WriteCZ = 1'b0; DataA = 8'h00; DataB = 8'h00;
        repeat (2) @(negedge Clk);
        check("reset ready", 32'(Ready), 32'd1);
        check("reset done", 32'(Done), 32'd0);
        check("reset dataout", 32'(DataOut), 32'd0);
        check("reset flags", 32'({CF, ZF, NF, VF}), 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        run_op("add_wrap", 4'h4, 8'hFF, 8'h01, 1'b1, 0, 1, 8'h00, 4'b1100);
        run_op("adc_cin",  4'hC, 8'h00, 8'h00, 1'b1, 0, 1, 8'h01, 4'b0000);
        run_op("sub_ovf",  4'h5, 8'h80, 8'h01, 1'b1, 0, 1, 8'h7F, 4'b0001);
        run_op("sub_nowr", 4'h5, 8'h01, 8'h02, 1'b0, 0, 1, 8'hFF, 4'b0001);
        d0 = done_cnt;
        run_op("shln3",    4'hE, 8'h81, 8'h03, 1'b1, 1, 4, 8'h08, 4'b0000);
        repeat (3) @(negedge Clk);
        check("shln3 one_done", 32'(done_cnt - d0), 32'd1);
        run_op("mul",      4'hF, 8'h10, 8'h11, 1'b1, 2, 9, 8'h10, 4'b1000);
        run_op("inca_wrap", 4'h2, 8'hFF, 8'h00, 1'b1, 0, 1, 8'h00, 4'b1100);
        run_op("shrn0",    4'hD, 8'h81, 8'h10, 1'b1, 0, 1, 8'h81, 4'b0010);
        run_op("shrn1",    4'hD, 8'h81, 8'h01, 1'b1, 0, 2, 8'h40, 4'b1000);
        run_op("sub_borrow", 4'h5, 8'h01, 8'h02, 1'b1, 0, 1, 8'hFF, 4'b1010);

        // Reset asserted mid-multiply: op is abandoned.
        d0 = done_cnt;
        ALUSel = 4'hF; DataA = 8'h03; DataB = 8'h05; WriteCZ = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("rst_mul done", 32'(Done), 32'd0);
        check("rst_mul dataout", 32'(DataOut), 32'd0);
        check("rst_mul flags", 32'({CF, ZF, NF, VF}), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        check("rst_mul ready", 32'(Ready), 32'd1);
        repeat (12) @(negedge Clk);
        check("rst_mul no_done", 32'(done_cnt - d0), 32'd0);

        // Back-to-back randomised ops against the reference model.
        m_flags = 4'b0000;
        m_out   = 8'h00;
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = 8'($urandom);
            b   = 8'($urandom);
            wcz = 1'($urandom);
            rv  = ref_alu(op, a, b, m_flags[3]);
            m_out = rv[7:0];
            if (wcz) m_flags = {rv[9], (rv[7:0] == 8'h00), rv[7], rv[8]};
            if (op == 4'hF)      lat = 9;
            else if (op >= 4'hD) lat = int'(b[2:0]) + 1;
            else                 lat = 1;
            run_op($sformatf("rand%0d_op%0h", i, op), op, a, b, wcz, 0, lat, m_out, m_flags);
        end
        check("rand done_count", 32'(done_cnt - d0), 32'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
